pipe_reg_monitor: RTL and testbench

- Synthesizable run/dump monitor attached beside Pipe_CPU.
- Counts cycles after start and captures register-file writebacks to a configurable set of watched registers into a trace FIFO.
- At a programmable end count it sequences a full register-file dump over a valid/ready stream.
- Generalises the fixed 100-cycle run, full 32-register dump and hard-wired $1/$9 watch to parametrised depth, width, watch-channel count and back-pressured outputs.

---
 rtl/pipe_reg_monitor.sv | 197 +++++++++++++++++++
 tb/tb_pipe_reg_monitor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_monitor.sv
// Run/dump monitor beside a pipelined CPU: counts RUN cycles, traces watched writebacks, then streams a register-file dump.
// Optional build macro MON_STALL_TIMEOUT_EN adds an idle-writeback watchdog that ends RUN early.
module pipe_reg_monitor #(
  parameter int DATA_W      = 32,
  parameter int REG_NUM     = 32,
  parameter int ADDR_W      = 5,
  parameter int END_COUNT   = 100,
  parameter int NUM_WATCH   = 2,
  parameter int TRACE_DEPTH = 16,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic                        wb_en_i,
  input  logic [ADDR_W-1:0]           wb_addr_i,
  input  logic [DATA_W-1:0]           wb_data_i,
  input  logic [NUM_WATCH*ADDR_W-1:0] watch_addr_i,
  output logic [ADDR_W-1:0]           rf_rd_addr_o,
  input  logic [DATA_W-1:0]           rf_rd_data_i,
  output logic                        dump_valid_o,
  input  logic                        dump_ready_i,
  output logic [ADDR_W-1:0]           dump_addr_o,
  output logic [DATA_W-1:0]           dump_data_o,
  output logic                        trace_valid_o,
  input  logic                        trace_ready_i,
  output logic [ADDR_W-1:0]           trace_addr_o,
  output logic [DATA_W-1:0]           trace_data_o,
  output logic [CNT_W-1:0]            cycle_cnt_o,
  output logic [1:0]                  state_o,
  output logic                        done_o,
  output logic                        overflow_o,
  output logic                        timeout_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DUMP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam int ENT_W = ADDR_W + DATA_W;

  if (REG_NUM > (1 << ADDR_W) || END_COUNT < 1 || NUM_WATCH < 1 || TRACE_DEPTH < 2 ||
      (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("pipe_reg_monitor: illegal parameter set");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]        state;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [ADDR_W-1:0] dump_idx;
  logic              dump_last;
  logic              dump_valid;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              done;
  logic              overflow;
  logic              run_end;
  logic              stall_to;
  logic              dump_take;

  logic              watch_hit;
  logic              push;
  logic              pop;
  logic              push_ok;
  logic              empty;
  logic              full;
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic [ENT_W-1:0]  mem [TRACE_DEPTH];
  logic [ENT_W-1:0]  head;

  // Duplicate watch channels collapse into a single hit.
  always_comb begin
    watch_hit = 1'b0;
    for (int k = 0; k < NUM_WATCH; k++) begin
      if (wb_addr_i == watch_addr_i[k*ADDR_W +: ADDR_W]) watch_hit = 1'b1;
    end
  end

  assign push    = (state == S_RUN) && wb_en_i && (wb_addr_i != '0) && watch_hit;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop     = !empty && trace_ready_i;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= {wb_addr_i, wb_data_i};
  end

  assign head          = mem[rd_ptr[PTR_W-1:0]];
  assign trace_valid_o = !empty;
  assign trace_addr_o  = empty ? '0 : head[ENT_W-1:DATA_W];
  assign trace_data_o  = empty ? '0 : head[DATA_W-1:0];

`ifdef MON_STALL_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_cnt;
  logic              timeout_q;

  // Fires on the edge where the idle count would reach TIMEOUT.
  assign stall_to = (state == S_RUN) && !wb_en_i && (idle_cnt == IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state != S_RUN || wb_en_i) idle_cnt <= '0;
      else                           idle_cnt <= idle_cnt + IDLE_W'(1);
      if (stall_to) timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign stall_to  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign run_end   = (cycle_cnt == CNT_W'(END_COUNT - 1));
  assign dump_take = (state == S_DUMP) && !dump_last && (!dump_valid || dump_ready_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      cycle_cnt  <= '0;
      dump_idx   <= '0;
      dump_last  <= 1'b0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state     <= S_RUN;
            cycle_cnt <= '0;
          end
        end
        S_RUN: begin
          if (stall_to) begin
            state <= S_DUMP;
          end else begin
            cycle_cnt <= sat_inc(cycle_cnt);
            if (run_end) state <= S_DUMP;
          end
        end
        S_DUMP: begin
          if (dump_take) begin
            dump_data  <= rf_rd_data_i;
            dump_addr  <= dump_idx;
            dump_valid <= 1'b1;
            dump_idx   <= dump_idx + ADDR_W'(1);
            if (dump_idx == ADDR_W'(REG_NUM - 1)) dump_last <= 1'b1;
          end else if (dump_valid && dump_ready_i) begin
            // Only reachable once the final beat has been issued.
            dump_valid <= 1'b0;
            state      <= S_DONE;
            done       <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rf_rd_addr_o = dump_idx;
  assign dump_valid_o = dump_valid;
  assign dump_addr_o  = dump_addr;
  assign dump_data_o  = dump_data;
  assign cycle_cnt_o  = cycle_cnt;
  assign state_o      = state;
  assign done_o       = done;
  assign overflow_o   = overflow;

endmodule

// File: tb/tb_pipe_reg_monitor.sv
// Scoreboard bench for pipe_reg_monitor: randomized writebacks and dump back-pressure against a queue-based reference model.
module tb_pipe_reg_monitor;
  localparam int DATA_W      = 32;
  localparam int REG_NUM     = 32;
  localparam int ADDR_W      = 5;
  localparam int END_COUNT   = 100;
  localparam int NUM_WATCH   = 2;
  localparam int TRACE_DEPTH = 16;
  localparam int CNT_W       = 16;
  localparam int TIMEOUT     = 64;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        rst, start, wb_en, dump_ready, trace_ready;
  logic [ADDR_W-1:0]           wb_addr, rf_rd_addr, dump_addr, trace_addr;
  logic [DATA_W-1:0]           wb_data, rf_rd_data, dump_data, trace_data;
  logic [NUM_WATCH*ADDR_W-1:0] watch;
  logic                        dump_valid, trace_valid, done, overflow, timeout;
  logic [CNT_W-1:0]            cycle_cnt;
  logic [1:0]                  state;

  logic [DATA_W-1:0] rf [REG_NUM];
  assign rf_rd_data = rf[rf_rd_addr];

  pipe_reg_monitor #(
    .DATA_W(DATA_W), .REG_NUM(REG_NUM), .ADDR_W(ADDR_W), .END_COUNT(END_COUNT),
    .NUM_WATCH(NUM_WATCH), .TRACE_DEPTH(TRACE_DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .wb_en_i(wb_en), .wb_addr_i(wb_addr),
    .wb_data_i(wb_data), .watch_addr_i(watch), .rf_rd_addr_o(rf_rd_addr),
    .rf_rd_data_i(rf_rd_data), .dump_valid_o(dump_valid), .dump_ready_i(dump_ready),
    .dump_addr_o(dump_addr), .dump_data_o(dump_data), .trace_valid_o(trace_valid),
    .trace_ready_i(trace_ready), .trace_addr_o(trace_addr), .trace_data_o(trace_data),
    .cycle_cnt_o(cycle_cnt), .state_o(state), .done_o(done), .overflow_o(overflow),
    .timeout_o(timeout)
  );

  int   total = 0;
  int   passed = 0;
  int   pushed = 0;
  int   trace_pops = 0;
  bit   exp_ovf = 1'b0;
  ent_t trace_q[$];
  ent_t dump_q[$];
  logic [ADDR_W-1:0] w0, w1;
  bit   dr_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Monitor: every presented dump beat must equal the model's next beat; accepted beats and trace pops retire entries.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (dump_valid) begin
          if (dump_q.size() == 0) chk("dump_extra_beat", dump_valid, 0);
          else begin
            chk("dump_addr", dump_addr, dump_q[0].a);
            chk("dump_data", dump_data, dump_q[0].d);
            if (dump_ready) void'(dump_q.pop_front());
          end
        end
        if (trace_valid && trace_ready) begin
          if (trace_q.size() == 0) chk("trace_extra_entry", trace_valid, 0);
          else begin
            e = trace_q.pop_front();
            chk("trace_pop_addr", trace_addr, e.a);
            chk("trace_pop_data", trace_data, e.d);
            trace_pops++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  // Drives one RUN-cycle writeback and records the expected FIFO effect at the coming edge.
  task automatic drive_wb(input bit en, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int pop_will;
    ent_t e;
    wb_en = en; wb_addr = a; wb_data = d;
    if (en && a != '0 && (a == w0 || a == w1)) begin
      pop_will = (trace_ready && trace_q.size() > 0) ? 1 : 0;
      if (trace_q.size() - pop_will < TRACE_DEPTH) begin
        e.a = a; e.d = d;
        trace_q.push_back(e);
        pushed++;
      end else begin
        exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic rand_wb();
    logic [ADDR_W-1:0] a;
    trace_ready = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 1) == 1) a = ($urandom_range(0, 1) == 1) ? w0 : w1;
    else a = ADDR_W'($urandom_range(0, REG_NUM - 1));
    drive_wb(1'($urandom_range(0, 1)), a, $urandom);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0; wb_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    trace_q.delete(); dump_q.delete(); exp_ovf = 1'b0;
  endtask

  // mode 0: directed trace; 1: fill/overflow; 2: random; 3: idle. abort_at >= 0 resets mid-dump.
  task automatic do_run(input int mode, input bit dr_mode, input int abort_at);
    int   sz, cyc;
    bit   ovf_seen;
    ent_t hd;
    ent_t e;
    pushed = 0; trace_pops = 0;
    for (int i = 0; i < REG_NUM; i++) rf[i] = $urandom;
    case (mode)
      0, 3:    begin w0 = 5'd1; w1 = 5'd9; end
      1:       begin w0 = 5'd5; w1 = 5'd5; end
      default: begin w0 = ADDR_W'($urandom_range(1, 31)); w1 = ADDR_W'($urandom_range(1, 31)); end
    endcase
    watch = {w1, w0};
    trace_ready = (mode != 1);
    dump_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; wb_en = 1'b1; wb_addr = w0; wb_data = $urandom;
    for (int k = 0; k < END_COUNT; k++) begin
      @(posedge clk); #1;
      start = (k == 5);
      sz = trace_q.size();
      ovf_seen = exp_ovf;
      if (sz > 0) hd = trace_q[0];
      case (mode)
        0: begin
          trace_ready = 1'b1;
          case (k)
            0:       drive_wb(1'b1, 5'd1, 32'h5);
            1:       drive_wb(1'b1, 5'd9, 32'hA);
            2:       drive_wb(1'b1, 5'd3, 32'h7);
            3:       drive_wb(1'b1, 5'd0, 32'h1);
            default: drive_wb(1'b0, 5'd0, 32'h0);
          endcase
        end
        1: begin
          if (k < 18) begin
            trace_ready = (k == 16);
            drive_wb(1'b1, 5'd5, $urandom);
          end else if (k < 30) begin
            trace_ready = 1'b0;
            drive_wb(1'b0, 5'd5, 32'h0);
          end else rand_wb();
        end
        2:       rand_wb();
        default: drive_wb(1'b0, 5'd0, 32'h0);
      endcase
      @(negedge clk);
      chk("run_state", state, 2'd1);
      chk("run_cycle_cnt", cycle_cnt, k);
      chk("run_overflow", overflow, ovf_seen);
      chk("trace_valid", trace_valid, (sz > 0));
      if (sz > 0) begin
        chk("trace_head_addr", trace_addr, hd.a);
        chk("trace_head_data", trace_data, hd.d);
      end
      if (mode == 1 && k == 17) chk("ovf_full_push_pop", overflow, 0);
      if (mode == 1 && k == 19) chk("ovf_after_17", overflow, 1);
    end
    @(posedge clk); #1;
    start = 1'b0; wb_en = 1'b1; wb_addr = w0; wb_data = $urandom;
    trace_ready = 1'b1;
    for (int i = 0; i < REG_NUM; i++) begin
      e.a = ADDR_W'(i); e.d = rf[i];
      dump_q.push_back(e);
    end
    @(negedge clk);
    chk("dump_state", state, 2'd2);
    chk("dump_cycle_cnt", cycle_cnt, END_COUNT);
    chk("dump_valid_at_entry", dump_valid, 0);
    cyc = 0;
    while (!done && cyc < 400) begin
      @(posedge clk); #1;
      wb_en = 1'b0;
      dump_ready = dr_mode ? dr_pat[cyc % 4] : 1'b1;
      @(negedge clk);
      if (cyc == 0) chk("dump_first_beat", dump_valid, 1);
      cyc++;
      if (abort_at >= 0 && dump_valid && dump_addr == ADDR_W'(abort_at)) begin
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        dump_q.delete(); trace_q.delete(); exp_ovf = 1'b0;
        @(negedge clk);
        chk("abort_state", state, 2'd0);
        chk("abort_dump_valid", dump_valid, 0);
        chk("abort_done", done, 0);
        chk("abort_trace_valid", trace_valid, 0);
        chk("abort_cycle_cnt", cycle_cnt, 0);
        return;
      end
    end
    chk("done_flag", done, 1);
    chk("done_state", state, 2'd3);
    chk("done_dump_valid", dump_valid, 0);
    chk("dump_beats_left", dump_q.size(), 0);
    for (int i = 0; i < 64 && trace_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("trace_left", trace_q.size(), 0);
    chk("trace_valid_drained", trace_valid, 0);
    chk("trace_pop_count", trace_pops, pushed);
    if (mode == 0) chk("trace_two_entries", trace_pops, 2);
    chk("overflow_final", overflow, exp_ovf);
    chk("timeout_off", timeout, 0);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("done_ignores_start", state, 2'd3);
    chk("done_sticky", done, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    trace_ready = 1'b0; dump_ready = 1'b0; watch = '0; w0 = '0; w1 = '0;
    for (int i = 0; i < REG_NUM; i++) rf[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", state, 2'd0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_trace_valid", trace_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_rf_rd_addr", rf_rd_addr, 0);
    chk("rst_dump_addr", dump_addr, 0);
    chk("rst_dump_data", dump_data, 0);
    chk("rst_trace_addr", trace_addr, 0);
    chk("rst_trace_data", trace_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_run(0, 1'b0, -1);
    do_reset();
    do_run(1, 1'b1, -1);
    do_reset();
    do_run(3, 1'b0, 10);
    do_run(2, 1'b1, -1);
    do_reset();
    do_run(2, 1'b0, -1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
